// File: rtl/riscv_mem_arbiter_pkg.sv
// Shared definitions for the memory-port arbiter between the I-cache and
// D-cache refill/writeback paths.
//   state_e          : arbiter FSM encoding (IDLE=0, REQ=1, WDATA=2, RDATA=3, WACK=4)
//   OWNER_IC/OWNER_DC: owner encoding used on the owner output and last_owner
//   BEATS_DEF        : default beats per burst
package riscv_mem_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_REQ   = 3'd1,
    S_WDATA = 3'd2,
    S_RDATA = 3'd3,
    S_WACK  = 3'd4
  } state_e;

  localparam logic OWNER_IC = 1'b0;
  localparam logic OWNER_DC = 1'b1;

  localparam int ADDR_W_DEF = 32;
  localparam int DATA_W_DEF = 32;
  localparam int BEATS_DEF  = 4;

endpackage

// File: rtl/riscv_mem_arbiter_if.sv
// Bundle of every cache-side and memory-side signal of the memory arbiter.
//   master : the arbiter view (drives readies/responses to the caches and
//            requests/write beats to memory)
//   slave  : the environment view (caches and memory model)
interface riscv_mem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);

  // I-cache refill path
  logic              ic_req_valid;
  logic [ADDR_W-1:0] ic_req_addr;
  logic              ic_req_ready;
  logic              ic_resp_valid;
  logic [DATA_W-1:0] ic_resp_data;
  logic              ic_resp_last;

  // D-cache refill / writeback path
  logic              dc_req_valid;
  logic [ADDR_W-1:0] dc_req_addr;
  logic              dc_req_rw;
  logic              dc_req_ready;
  logic [DATA_W-1:0] dc_wdata;
  logic              dc_wdata_ready;
  logic              dc_resp_valid;
  logic [DATA_W-1:0] dc_resp_data;
  logic              dc_resp_last;

  // Main-memory port
  logic              mem_req_valid;
  logic [ADDR_W-1:0] mem_req_addr;
  logic              mem_req_rw;
  logic              mem_req_ready;
  logic              mem_wdata_valid;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_wdata_ready;
  logic              mem_resp_valid;
  logic [DATA_W-1:0] mem_resp_data;
  logic              mem_write_done;

  modport master (
    input  ic_req_valid, ic_req_addr,
    output ic_req_ready, ic_resp_valid, ic_resp_data, ic_resp_last,
    input  dc_req_valid, dc_req_addr, dc_req_rw, dc_wdata,
    output dc_req_ready, dc_wdata_ready, dc_resp_valid, dc_resp_data, dc_resp_last,
    output mem_req_valid, mem_req_addr, mem_req_rw, mem_wdata_valid, mem_wdata,
    input  mem_req_ready, mem_wdata_ready, mem_resp_valid, mem_resp_data, mem_write_done
  );

  modport slave (
    output ic_req_valid, ic_req_addr,
    input  ic_req_ready, ic_resp_valid, ic_resp_data, ic_resp_last,
    output dc_req_valid, dc_req_addr, dc_req_rw, dc_wdata,
    input  dc_req_ready, dc_wdata_ready, dc_resp_valid, dc_resp_data, dc_resp_last,
    input  mem_req_valid, mem_req_addr, mem_req_rw, mem_wdata_valid, mem_wdata,
    output mem_req_ready, mem_wdata_ready, mem_resp_valid, mem_resp_data, mem_write_done
  );

endinterface

// File: rtl/riscv_mem_arbiter_rr_arbiter2.sv
// Combinational 2-way round-robin grant.
//   ic_valid_i    : I-cache requesting
//   dc_valid_i    : D-cache requesting
//   last_owner_i  : owner of the previous grant
//   grant_o       : some requester is granted
//   grant_owner_o : granted requester (OWNER_IC / OWNER_DC)
module rr_arbiter2
  import riscv_mem_pkg::*;
(
  input  logic ic_valid_i,
  input  logic dc_valid_i,
  input  logic last_owner_i,
  output logic grant_o,
  output logic grant_owner_o
);

  always_comb begin
    grant_o       = ic_valid_i | dc_valid_i;
    grant_owner_o = OWNER_IC;
    if (ic_valid_i && dc_valid_i) begin
      // Tie: whoever did not win last time goes now.
      grant_owner_o = ~last_owner_i;
    end else if (dc_valid_i) begin
      grant_owner_o = OWNER_DC;
    end
  end

endmodule

// File: rtl/riscv_mem_arbiter.sv
// Shares the single main-memory burst port between the I-cache refill path
// and the D-cache refill/writeback path. One burst is in flight at a time.
//   clk   : clock, rising edge
//   rst   : asynchronous active-low reset
//   bus   : cache and memory handshake signals (riscv_mem_arbiter_if.master)
//   busy  : FSM not in IDLE
//   owner : 0 = I-cache, 1 = D-cache; meaningful while busy
module riscv_mem_arbiter
  import riscv_mem_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int BEATS  = BEATS_DEF
) (
  input  logic                clk,
  input  logic                rst,
  riscv_mem_arbiter_if.master bus,
  output logic                busy,
  output logic                owner
);

  localparam int              CNT_W     = $clog2(BEATS);
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                last_owner_q, last_owner_d;
  logic                owner_q, owner_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                rw_q, rw_d;

  logic                ic_cand, dc_cand;
  logic                grant, grant_owner;

  // No grant may be signalled while reset is held, even though the
  // state register already reads IDLE.
  assign ic_cand = bus.ic_req_valid & rst;
  assign dc_cand = bus.dc_req_valid & rst;

  rr_arbiter2 u_rr (
    .ic_valid_i    (ic_cand),
    .dc_valid_i    (dc_cand),
    .last_owner_i  (last_owner_q),
    .grant_o       (grant),
    .grant_owner_o (grant_owner)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      last_owner_q <= OWNER_IC;
      owner_q      <= OWNER_IC;
      addr_q       <= '0;
      rw_q         <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      last_owner_q <= last_owner_d;
      owner_q      <= owner_d;
      addr_q       <= addr_d;
      rw_q         <= rw_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    last_owner_d = last_owner_q;
    owner_d      = owner_q;
    addr_d       = addr_q;
    rw_d         = rw_q;

    bus.ic_req_ready    = 1'b0;
    bus.ic_resp_valid   = 1'b0;
    bus.ic_resp_data    = '0;
    bus.ic_resp_last    = 1'b0;
    bus.dc_req_ready    = 1'b0;
    bus.dc_wdata_ready  = 1'b0;
    bus.dc_resp_valid   = 1'b0;
    bus.dc_resp_data    = '0;
    bus.dc_resp_last    = 1'b0;
    bus.mem_req_valid   = 1'b0;
    bus.mem_wdata_valid = 1'b0;
    bus.mem_wdata       = '0;

    unique case (state_q)
      S_IDLE: begin
        if (grant) begin
          bus.ic_req_ready = (grant_owner == OWNER_IC);
          bus.dc_req_ready = (grant_owner == OWNER_DC);
          addr_d       = (grant_owner == OWNER_DC) ? bus.dc_req_addr : bus.ic_req_addr;
          rw_d         = (grant_owner == OWNER_DC) ? bus.dc_req_rw : 1'b0;
          owner_d      = grant_owner;
          last_owner_d = grant_owner;
          state_d      = S_REQ;
        end
      end
      S_REQ: begin
        bus.mem_req_valid = 1'b1;
        if (bus.mem_req_ready) begin
          cnt_d   = '0;
          state_d = rw_q ? S_WDATA : S_RDATA;
        end
      end
      S_WDATA: begin
        // Only the D-cache can own a write burst, so its beat goes straight out.
        bus.mem_wdata_valid = 1'b1;
        bus.mem_wdata       = bus.dc_wdata;
        bus.dc_wdata_ready  = bus.mem_wdata_ready;
        if (bus.mem_wdata_ready) begin
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == LAST_BEAT) begin
            state_d = S_WACK;
          end
        end
      end
      S_RDATA: begin
        if (bus.mem_resp_valid) begin
          if (owner_q == OWNER_DC) begin
            bus.dc_resp_valid = 1'b1;
            bus.dc_resp_data  = bus.mem_resp_data;
            bus.dc_resp_last  = (cnt_q == LAST_BEAT);
          end else begin
            bus.ic_resp_valid = 1'b1;
            bus.ic_resp_data  = bus.mem_resp_data;
            bus.ic_resp_last  = (cnt_q == LAST_BEAT);
          end
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == LAST_BEAT) begin
            state_d = S_IDLE;
          end
        end
      end
      S_WACK: begin
        if (bus.mem_write_done) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign bus.mem_req_addr = addr_q;
  assign bus.mem_req_rw   = rw_q;
  assign busy             = (state_q != S_IDLE);
  assign owner            = owner_q;

endmodule

// File: tb/tb_riscv_mem_arbiter.sv
module tb_riscv_mem_arbiter;

  logic clk;
  logic rst;
  logic busy;
  logic owner;

  int pass_cnt;
  int total_cnt;

  riscv_mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  riscv_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .BEATS(4)) dut (
    .clk   (clk),
    .rst   (rst),
    .bus   (bus),
    .busy  (busy),
    .owner (owner)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to just after the next rising edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.ic_req_valid    = 1'b0;
    bus.ic_req_addr     = '0;
    bus.dc_req_valid    = 1'b0;
    bus.dc_req_addr     = '0;
    bus.dc_req_rw       = 1'b0;
    bus.dc_wdata        = '0;
    bus.mem_req_ready   = 1'b0;
    bus.mem_wdata_ready = 1'b0;
    bus.mem_resp_valid  = 1'b0;
    bus.mem_resp_data   = '0;
    bus.mem_write_done  = 1'b0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst = 1'b0;
    cyc();
    cyc();
    rst = 1'b1;
  endtask

  // From REQ: accept the request and feed four read beats; ends in IDLE.
  task automatic run_read_burst(input logic [31:0] base);
    bus.mem_req_ready = 1'b1;
    cyc();
    bus.mem_req_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      bus.mem_resp_valid = 1'b1;
      bus.mem_resp_data  = base + 32'(i);
      cyc();
    end
    bus.mem_resp_valid = 1'b0;
    bus.mem_resp_data  = '0;
  endtask

  task automatic test_reset();
    clear_inputs();
    rst = 1'b0;
    bus.ic_req_valid   = 1'b1;
    bus.ic_req_addr    = 32'h1234;
    bus.mem_resp_valid = 1'b1;
    bus.mem_resp_data  = 32'hDEAD;
    cyc();
    total_cnt++;
    if (busy !== 1'b0) $display("FAIL reset_busy got=%b exp=0", busy); else pass_cnt++;
    total_cnt++;
    if (owner !== 1'b0) $display("FAIL reset_owner got=%b exp=0", owner); else pass_cnt++;
    total_cnt++;
    if (bus.ic_req_ready !== 1'b0) $display("FAIL reset_ic_ready got=%b exp=0", bus.ic_req_ready); else pass_cnt++;
    total_cnt++;
    if (bus.ic_resp_valid !== 1'b0 || bus.ic_resp_data !== 32'h0)
      $display("FAIL reset_ic_resp got=%b/%h exp=0/0", bus.ic_resp_valid, bus.ic_resp_data);
    else pass_cnt++;
    total_cnt++;
    if (bus.mem_req_valid !== 1'b0 || bus.mem_req_addr !== 32'h0)
      $display("FAIL reset_mem_req got=%b/%h exp=0/0", bus.mem_req_valid, bus.mem_req_addr);
    else pass_cnt++;
    clear_inputs();
    cyc();
    rst = 1'b1;
    cyc();
  endtask

  task automatic test_ic_read();
    bus.ic_req_valid = 1'b1;
    bus.ic_req_addr  = 32'h2000;
    #1;
    total_cnt++;
    if (bus.ic_req_ready !== 1'b1 || bus.dc_req_ready !== 1'b0)
      $display("FAIL ic_grant got ic=%b dc=%b exp ic=1 dc=0", bus.ic_req_ready, bus.dc_req_ready);
    else pass_cnt++;
    cyc();
    bus.ic_req_valid = 1'b0;
    #1;
    total_cnt++;
    if (bus.mem_req_valid !== 1'b1 || bus.mem_req_addr !== 32'h2000 || bus.mem_req_rw !== 1'b0)
      $display("FAIL ic_mem_req got=%b/%h/%b exp=1/00002000/0",
               bus.mem_req_valid, bus.mem_req_addr, bus.mem_req_rw);
    else pass_cnt++;
    total_cnt++;
    if (busy !== 1'b1 || owner !== 1'b0) $display("FAIL ic_busy_owner got=%b/%b exp=1/0", busy, owner);
    else pass_cnt++;
    cyc();
    cyc();
    total_cnt++;
    if (bus.mem_req_valid !== 1'b1) $display("FAIL ic_req_hold got=%b exp=1", bus.mem_req_valid);
    else pass_cnt++;
    bus.mem_req_ready = 1'b1;
    cyc();
    bus.mem_req_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      bus.mem_resp_valid = 1'b1;
      bus.mem_resp_data  = 32'hA0 + 32'(i);
      #1;
      total_cnt++;
      if (bus.ic_resp_valid !== 1'b1 || bus.ic_resp_data !== 32'hA0 + 32'(i) ||
          bus.ic_resp_last !== (i == 3) || bus.dc_resp_valid !== 1'b0)
        $display("FAIL ic_beat%0d got v=%b d=%h l=%b dcv=%b exp v=1 d=%h l=%b dcv=0", i,
                 bus.ic_resp_valid, bus.ic_resp_data, bus.ic_resp_last, bus.dc_resp_valid,
                 32'hA0 + 32'(i), (i == 3));
      else pass_cnt++;
      cyc();
    end
    bus.mem_resp_valid = 1'b0;
    #1;
    total_cnt++;
    if (busy !== 1'b0) $display("FAIL ic_done_busy got=%b exp=0", busy); else pass_cnt++;
  endtask

  task automatic test_simultaneous();
    do_reset();
    bus.ic_req_valid = 1'b1;
    bus.ic_req_addr  = 32'h100;
    bus.dc_req_valid = 1'b1;
    bus.dc_req_addr  = 32'h200;
    bus.dc_req_rw    = 1'b0;
    #1;
    total_cnt++;
    if (bus.dc_req_ready !== 1'b1 || bus.ic_req_ready !== 1'b0)
      $display("FAIL tie_first got ic=%b dc=%b exp ic=0 dc=1", bus.ic_req_ready, bus.dc_req_ready);
    else pass_cnt++;
    cyc();
    bus.dc_req_valid = 1'b0;
    #1;
    total_cnt++;
    if (owner !== 1'b1 || bus.mem_req_addr !== 32'h200 || bus.ic_req_ready !== 1'b0)
      $display("FAIL tie_dc_owner got own=%b addr=%h icr=%b exp 1/00000200/0",
               owner, bus.mem_req_addr, bus.ic_req_ready);
    else pass_cnt++;
    bus.mem_req_ready = 1'b1;
    cyc();
    bus.mem_req_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      bus.mem_resp_valid = 1'b1;
      bus.mem_resp_data  = 32'hB0 + 32'(i);
      #1;
      total_cnt++;
      if (bus.dc_resp_valid !== 1'b1 || bus.dc_resp_data !== 32'hB0 + 32'(i) ||
          bus.ic_resp_valid !== 1'b0 || bus.ic_resp_data !== 32'h0)
        $display("FAIL dc_beat%0d got dcv=%b d=%h icv=%b icd=%h exp 1/%h/0/0", i,
                 bus.dc_resp_valid, bus.dc_resp_data, bus.ic_resp_valid, bus.ic_resp_data,
                 32'hB0 + 32'(i));
      else pass_cnt++;
      cyc();
    end
    bus.mem_resp_valid = 1'b0;
    #1;
    total_cnt++;
    if (bus.ic_req_ready !== 1'b1) $display("FAIL tie_ic_next got=%b exp=1", bus.ic_req_ready);
    else pass_cnt++;
    cyc();
    bus.ic_req_valid = 1'b0;
    #1;
    total_cnt++;
    if (owner !== 1'b0 || bus.mem_req_addr !== 32'h100)
      $display("FAIL tie_ic_owner got own=%b addr=%h exp 0/00000100", owner, bus.mem_req_addr);
    else pass_cnt++;
    run_read_burst(32'hE0);
  endtask

  task automatic test_writeback();
    logic [31:0] wd [4];
    int k;
    int c;
    wd[0] = 32'h11; wd[1] = 32'h22; wd[2] = 32'h33; wd[3] = 32'h44;
    bus.dc_req_valid = 1'b1;
    bus.dc_req_addr  = 32'h300;
    bus.dc_req_rw    = 1'b1;
    #1;
    total_cnt++;
    if (bus.dc_req_ready !== 1'b1) $display("FAIL wb_grant got=%b exp=1", bus.dc_req_ready);
    else pass_cnt++;
    cyc();
    bus.dc_req_valid = 1'b0;
    bus.dc_req_rw    = 1'b0;
    #1;
    total_cnt++;
    if (bus.mem_req_rw !== 1'b1 || bus.mem_req_addr !== 32'h300)
      $display("FAIL wb_req got rw=%b addr=%h exp 1/00000300", bus.mem_req_rw, bus.mem_req_addr);
    else pass_cnt++;
    bus.mem_req_ready = 1'b1;
    cyc();
    bus.mem_req_ready = 1'b0;
    k = 0;
    c = 0;
    while (k < 4 && c < 20) begin
      bus.mem_wdata_ready = (c % 2 == 0);
      bus.dc_wdata        = wd[k];
      #1;
      total_cnt++;
      if (bus.mem_wdata_valid !== 1'b1 || bus.mem_wdata !== wd[k] ||
          bus.dc_wdata_ready !== bus.mem_wdata_ready)
        $display("FAIL wb_beat%0d got v=%b d=%h rdy=%b exp v=1 d=%h rdy=%b", k,
                 bus.mem_wdata_valid, bus.mem_wdata, bus.dc_wdata_ready, wd[k], bus.mem_wdata_ready);
      else pass_cnt++;
      cyc();
      if (bus.mem_wdata_ready) k++;
      c++;
    end
    bus.mem_wdata_ready = 1'b0;
    bus.dc_wdata        = '0;
    total_cnt++;
    if (k !== 4) $display("FAIL wb_beats_timeout got=%0d exp=4", k); else pass_cnt++;
    #1;
    total_cnt++;
    if (bus.mem_wdata_valid !== 1'b0 || busy !== 1'b1)
      $display("FAIL wb_wack got wv=%b busy=%b exp 0/1", bus.mem_wdata_valid, busy);
    else pass_cnt++;
    cyc();
    cyc();
    total_cnt++;
    if (busy !== 1'b1) $display("FAIL wb_wait_ack got=%b exp=1", busy); else pass_cnt++;
    bus.mem_write_done = 1'b1;
    cyc();
    bus.mem_write_done = 1'b0;
    #1;
    total_cnt++;
    if (busy !== 1'b0) $display("FAIL wb_done got=%b exp=0", busy); else pass_cnt++;
  endtask

  task automatic test_fairness();
    logic exp_own;
    do_reset();
    bus.ic_req_valid = 1'b1;
    bus.ic_req_addr  = 32'h400;
    bus.dc_req_valid = 1'b1;
    bus.dc_req_addr  = 32'h500;
    bus.dc_req_rw    = 1'b0;
    for (int b = 0; b < 4; b++) begin
      exp_own = (b % 2 == 0);
      #1;
      total_cnt++;
      if (bus.dc_req_ready !== exp_own || bus.ic_req_ready !== ~exp_own)
        $display("FAIL fair_grant%0d got ic=%b dc=%b exp dc=%b", b,
                 bus.ic_req_ready, bus.dc_req_ready, exp_own);
      else pass_cnt++;
      cyc();
      total_cnt++;
      if (owner !== exp_own) $display("FAIL fair_owner%0d got=%b exp=%b", b, owner, exp_own);
      else pass_cnt++;
      run_read_burst(32'h10 * 32'(b));
    end
    bus.ic_req_valid = 1'b0;
    bus.dc_req_valid = 1'b0;
    cyc();
  endtask

  task automatic test_reset_mid();
    bus.ic_req_valid = 1'b1;
    bus.ic_req_addr  = 32'h4000;
    cyc();
    bus.ic_req_valid  = 1'b0;
    bus.mem_req_ready = 1'b1;
    cyc();
    bus.mem_req_ready  = 1'b0;
    bus.mem_resp_valid = 1'b1;
    bus.mem_resp_data  = 32'hC0;
    cyc();
    bus.mem_resp_data  = 32'hC1;
    cyc();
    bus.mem_resp_data  = 32'hC2;
    #1;
    total_cnt++;
    if (bus.ic_resp_valid !== 1'b1) $display("FAIL mid_pre got=%b exp=1", bus.ic_resp_valid);
    else pass_cnt++;
    #1;
    rst = 1'b0;
    #1;
    total_cnt++;
    if (bus.ic_resp_valid !== 1'b0 || bus.ic_resp_data !== 32'h0 || busy !== 1'b0 ||
        owner !== 1'b0 || bus.mem_req_valid !== 1'b0)
      $display("FAIL mid_async got v=%b d=%h busy=%b own=%b mrv=%b exp all 0",
               bus.ic_resp_valid, bus.ic_resp_data, busy, owner, bus.mem_req_valid);
    else pass_cnt++;
    clear_inputs();
    cyc();
    rst = 1'b1;
    bus.ic_req_valid = 1'b1;
    bus.ic_req_addr  = 32'h5000;
    #1;
    total_cnt++;
    if (bus.ic_req_ready !== 1'b1) $display("FAIL mid_regrant got=%b exp=1", bus.ic_req_ready);
    else pass_cnt++;
    cyc();
    bus.ic_req_valid  = 1'b0;
    bus.mem_req_ready = 1'b1;
    #1;
    total_cnt++;
    if (bus.mem_req_addr !== 32'h5000) $display("FAIL mid_addr got=%h exp=00005000", bus.mem_req_addr);
    else pass_cnt++;
    cyc();
    bus.mem_req_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      bus.mem_resp_valid = 1'b1;
      bus.mem_resp_data  = 32'hD0 + 32'(i);
      #1;
      total_cnt++;
      if (bus.ic_resp_valid !== 1'b1 || bus.ic_resp_last !== (i == 3))
        $display("FAIL mid_beat%0d got v=%b l=%b exp v=1 l=%b", i,
                 bus.ic_resp_valid, bus.ic_resp_last, (i == 3));
      else pass_cnt++;
      cyc();
    end
    bus.mem_resp_valid = 1'b0;
    #1;
    total_cnt++;
    if (busy !== 1'b0) $display("FAIL mid_end got=%b exp=0", busy); else pass_cnt++;
  endtask

  task automatic test_spurious();
    bus.mem_resp_valid = 1'b1;
    bus.mem_resp_data  = 32'h5A5A;
    bus.mem_write_done = 1'b1;
    #1;
    total_cnt++;
    if (bus.ic_resp_valid !== 1'b0 || bus.dc_resp_valid !== 1'b0)
      $display("FAIL spur_resp got ic=%b dc=%b exp 0/0", bus.ic_resp_valid, bus.dc_resp_valid);
    else pass_cnt++;
    cyc();
    total_cnt++;
    if (busy !== 1'b0) $display("FAIL spur_busy got=%b exp=0", busy); else pass_cnt++;
    cyc();
    clear_inputs();
    #1;
    total_cnt++;
    if (busy !== 1'b0 || bus.mem_req_valid !== 1'b0)
      $display("FAIL spur_idle got busy=%b mrv=%b exp 0/0", busy, bus.mem_req_valid);
    else pass_cnt++;
  endtask

  initial begin
    pass_cnt  = 0;
    total_cnt = 0;
    rst       = 1'b0;
    clear_inputs();
    test_reset();
    test_ic_read();
    test_simultaneous();
    test_writeback();
    test_fairness();
    test_reset_mid();
    test_spurious();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/riscv_mem_arbiter.md
Name: riscv_mem_arbiter

Overview:
- Shares the single main-memory port between the instruction-cache refill path and the data-cache refill/writeback path of the 5-stage RISC-V core.
- Sits between the two cache controllers and the memory interface.
- Accepts one burst transaction at a time, arbitrates round-robin when both caches request in the same cycle, and routes read beats and write beats to and from the granted cache.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, beat width.
- BEATS, 4, beats per burst (power of two, >=2).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset (asserted when 0).
- ic_req_valid  in  1  I-cache refill request.
- ic_req_addr  in  ADDR_W  line-aligned refill address.
- ic_req_ready  out  1  request accepted this cycle.
- ic_resp_valid  out  1  read beat valid for I-cache.
- ic_resp_data  out  DATA_W  read beat.
- ic_resp_last  out  1  final beat of burst.
- dc_req_valid  in  1  D-cache request.
- dc_req_addr  in  ADDR_W  line-aligned address.
- dc_req_rw  in  1  1 = writeback, 0 = refill.
- dc_req_ready  out  1  request accepted.
- dc_wdata  in  DATA_W  writeback beat, held until dc_wdata_ready.
- dc_wdata_ready  out  1  current writeback beat consumed.
- dc_resp_valid  out  1  read beat valid for D-cache.
- dc_resp_data  out  DATA_W  read beat.
- dc_resp_last  out  1  final beat.
- mem_req_valid  out  1  burst request to memory.
- mem_req_addr  out  ADDR_W  burst address.
- mem_req_rw  out  1  1 = write.
- mem_req_ready  in  1  memory accepts request.
- mem_wdata_valid  out  1  write beat valid.
- mem_wdata  out  DATA_W  write beat.
- mem_wdata_ready  in  1  memory accepts write beat.
- mem_resp_valid  in  1  read beat from memory.
- mem_resp_data  in  DATA_W  read beat.
- mem_write_done  in  1  write burst acknowledged.
- busy  out  1  state != IDLE.
- owner  out  1  0 = I-cache, 1 = D-cache; valid while busy.

Behaviour:
- Reset:
  - rst low forces state IDLE, beat counter 0, last_owner 0, owner 0, latched address/rw 0.
  - All valid/ready outputs are 0, all data outputs are 0.
  - Asserting reset mid-burst aborts the burst immediately. Memory-side recovery belongs to the system reset.
- States: IDLE, REQ, WDATA, RDATA, WACK.
- IDLE:
  - Arbitrate among the pending requesters.
    - Only one valid: grant it.
    - Both valid: grant the one that is not last_owner (D-cache wins the first tie after reset, because last_owner resets to 0).
  - In the grant cycle, pulse the granted *_req_ready for 1 cycle (combinational from the valids and last_owner).
  - Latch addr, rw (I-cache is always read), and owner. Set last_owner <= owner. Go to REQ.
- REQ:
  - Hold mem_req_valid=1 with the latched addr/rw until mem_req_ready.
  - On handshake: rw=1 goes to WDATA, rw=0 goes to RDATA. Clear the beat counter.
- WDATA:
  - mem_wdata_valid=1 and mem_wdata=dc_wdata.
  - dc_wdata_ready = mem_wdata_ready (same cycle, combinational pass-through).
  - Each handshake increments the counter.
  - The handshake at counter == BEATS-1 goes to WACK.
- WACK:
  - Wait for mem_write_done, then return to IDLE.
- RDATA:
  - Each mem_resp_valid is steered combinationally to the owner's resp_valid/resp_data. The other requester sees resp_valid=0, and its data output is held at 0.
  - resp_last is 1 when counter == BEATS-1.
  - The counter increments on each beat. The last beat goes to IDLE.
  - Caches cannot stall read beats.
- Request timing: new requests are not accepted while busy. The earliest next grant is the cycle after returning to IDLE, so back-to-back bursts have one idle cycle between them.
- Boundary conditions:
  - The counter is log2(BEATS) bits and never wraps mid-burst.
  - mem_resp_valid outside RDATA is ignored.
  - mem_write_done outside WACK is ignored.
  - A requester deasserting valid while not granted has no effect.
- Ownership: a granted requester is only acted on in its grant cycle. The arbiter holds ownership until the burst completes.

Decomposition:
- Shared package riscv_mem_pkg:
  - state encoding enum (IDLE=0, REQ=1, WDATA=2, RDATA=3, WACK=4).
  - OWNER_IC/OWNER_DC constants.
  - BEATS default.
- One sub-module, rr_arbiter2: the combinational 2-way round-robin grant from the valids and last_owner.

Test Plan:
- Single I-cache read: ic_req at 0x2000, mem_req_ready after 2 cycles, 4 beats 0xA0..0xA3 -> mem_req_addr=0x2000, rw=0; ic_resp_valid on 4 beats with matching data; ic_resp_last on 0xA3; dc_resp_valid stays 0; busy clears the next cycle.
- Simultaneous requests after reset: ic@0x100 and dc read@0x200 both valid -> D-cache granted first; I-cache granted in the IDLE cycle after the D burst; owner sequence 1 then 0.
- D-cache writeback: dc rw=1 at 0x300, wdata 0x11..0x44, mem_wdata_ready toggling 1/0 -> exactly 4 mem_wdata beats in order; dc_wdata_ready mirrors mem_wdata_ready; IDLE reached only after mem_write_done.
- Fairness: both requesters held valid for 4 bursts -> grants alternate D, I, D, I; no requester is starved.
- Reset mid-burst: rst low during beat 2 of RDATA -> all outputs 0 asynchronously; after release, a new ic_req is granted normally and the counter restarts at 0.
- Spurious memory signals: mem_resp_valid and mem_write_done pulsed in IDLE -> no resp_valid on either cache; state stays IDLE.
